frame_aligned_rst_ctrl: RTL and testbench
=========================================

# frame_aligned_rst_ctrl

- Multi-channel, parametrised frame-boundary reset controller for AXI4-Stream video paths.
- Each channel holds its downstream reset asserted for a minimum number of cycles. It then waits a configurable number of start-of-frame (SOF) beats and releases on the exact SOF beat, so the downstream logic sees a whole frame.
- An optional timeout releases the reset and sets a flag if video never arrives.
- Sits between the global reset and the per-stream debug and processing pipelines.

## Interface
Parameters:
- NUM_CH, 2: number of independent video channels (1–16).
- MIN_RST_CYCLES, 16: minimum cycles the output stays low after the cause of reset clears (≥1).
- HOLD_FRAMES, 0: number of SOF beats to skip before the releasing SOF (0 = release on the first SOF).
- TIMEOUT_CYCLES, 0: cycles allowed in ARMED before a forced release (0 = timeout disabled).

Ports:
- aclk, in, 1: the single clock; all logic is on the rising edge.
- resetn, in, 1: synchronous, active-low global reset.
- s_axis_tvalid, in, NUM_CH: per-channel TVALID monitor, bit ch belongs to channel ch.
- s_axis_tready, in, NUM_CH: per-channel TREADY monitor.
- s_axis_tuser, in, NUM_CH: per-channel TUSER[0] (SOF) monitor.
- rst_req, in, NUM_CH: per-channel soft reset request, sampled every cycle, level or pulse.
- resetn_internal, out, NUM_CH: per-channel frame-aligned active-low reset.
- timeout_flag, out, NUM_CH: sticky; the channel was released by timeout rather than by SOF.

## Operation
- sof[ch] = s_axis_tvalid[ch] & s_axis_tready[ch] & s_axis_tuser[ch].
- Each channel has its own FSM with states HOLD, ARMED and RUN.
- Each channel has three counters:
  - hold_cnt: width clog2(MIN_RST_CYCLES+1).
  - frm_cnt: width clog2(HOLD_FRAMES+1), minimum 1.
  - to_cnt: width clog2(TIMEOUT_CYCLES+1), minimum 1.
- No counter wraps; each saturates or is cleared on a state change.
- Priority in every state: resetn low, then rst_req[ch], then the SOF release or timeout, then counting.
- resetn low, any state: go to HOLD and clear all counters and timeout_flag[ch]. The output is 0.
- HOLD:
  - hold_cnt increments each cycle while resetn is high and rst_req[ch] is low.
  - rst_req[ch] high clears hold_cnt.
  - When hold_cnt = MIN_RST_CYCLES-1, go to ARMED and clear frm_cnt and to_cnt.
  - SOF beats in HOLD are ignored.
- ARMED:
  - sof[ch] with frm_cnt = HOLD_FRAMES: go to RUN. resetn_internal[ch] rises combinationally in that same cycle, so the SOF beat itself is out of reset.
  - sof[ch] with frm_cnt < HOLD_FRAMES: increment frm_cnt.
  - If TIMEOUT_CYCLES ≠ 0, to_cnt increments each cycle.
  - When to_cnt = TIMEOUT_CYCLES-1 and no releasing SOF occurs in that cycle: go to RUN and set timeout_flag[ch]. The output rises on the next cycle (registered).
  - rst_req[ch]: go to HOLD and clear hold_cnt.
- RUN:
  - The output is 1.
  - rst_req[ch]: go to HOLD and clear hold_cnt and timeout_flag[ch].
- resetn_internal[ch] = resetn & (state==RUN | (state==ARMED & sof[ch] & frm_cnt==HOLD_FRAMES & ~rst_req[ch])).
- Channels are fully independent; one channel's rst_req or SOF never affects another channel.

## Timing
- Reset values (resetn low): all FSMs in HOLD, resetn_internal = all zeros, timeout_flag = all zeros, all counters 0.
- resetn low forces resetn_internal low in the same cycle (combinational AND).
- The output stays low for at least MIN_RST_CYCLES cycles after resetn rises or rst_req falls.
- SOF release has 0-cycle latency from the sof beat; every other output change is registered, with 1-cycle latency.
- A sof beat in the same cycle as the HOLD→ARMED transition is not counted. Counting starts on the first cycle in ARMED.
- sof and rst_req in the same cycle while ARMED: rst_req wins. The output stays 0 and the channel goes to HOLD.
- sof and timeout expiry in the same cycle: the SOF release wins, and timeout_flag stays 0.
- A sof beat with tvalid high and tready low is not a beat and is never counted.
- resetn asserted mid-frame while in RUN: the output drops in the same cycle, and the full HOLD/ARMED sequence repeats.

## Test plan
- Defaults, NUM_CH=2:
  - Stimulus: resetn low for 5 cycles, then high; first SOF beat on ch0 at cycle 30.
  - Required: resetn_internal[0] = 0 through cycle 29, 1 during cycle 30 (combinationally, on the beat) and every cycle after.
  - Required: resetn_internal[1] stays 0 while ch1 has no SOF.
- SOF beat during HOLD (cycle 10 after reset release):
  - Required: the beat is ignored; release happens only on the first SOF at or after cycle 16.
- HOLD_FRAMES=2, SOF beats at cycles 20, 100, 180:
  - Required: the output is low at cycles 20 and 100 and rises at cycle 180.
  - Required: a stalled SOF (tvalid=1, tready=0) at cycle 60 is not counted.
- TIMEOUT_CYCLES=50, no SOF:
  - Required: the output rises exactly 50 cycles after entering ARMED, and timeout_flag goes to 1.
  - Required: a later rst_req pulse clears the flag and drops the output on the next edge.
- rst_req[1] pulse while both channels are in RUN:
  - Required: only ch1 drops, stays low for ≥16 cycles and re-releases on the next ch1 SOF; ch0 stays high throughout.
  - Required: rst_req[1] coinciding with a releasing SOF keeps the output 0.
- resetn pulsed low for 1 cycle mid-frame:
  - Required: all outputs drop in that cycle and the full release sequence repeats for every channel.

Source files
------------

// File: rtl/frame_aligned_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_aligned_rst_ctrl
// Brief    : Per-channel downstream reset that releases on an AXI4-Stream SOF.
// Revision : 1.0 - initial release
// ============================================================================
module frame_aligned_rst_ctrl #(
    parameter int NUM_CH         = 2,
    parameter int MIN_RST_CYCLES = 16,
    parameter int HOLD_FRAMES    = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              aclk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] s_axis_tvalid,
    input  logic [NUM_CH-1:0] s_axis_tready,
    input  logic [NUM_CH-1:0] s_axis_tuser,
    input  logic [NUM_CH-1:0] rst_req,
    output logic [NUM_CH-1:0] resetn_internal,
    output logic [NUM_CH-1:0] timeout_flag
);

    localparam int HOLD_W = $clog2(MIN_RST_CYCLES + 1);
    localparam int FRM_W  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_RST_CYCLES - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(HOLD_FRAMES);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit                TO_EN     = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_t            state, state_nxt;
        logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
        logic [FRM_W-1:0]  frm_cnt, frm_cnt_nxt;
        logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
        logic              flag, flag_nxt;
        logic              sof;
        logic              release_sof;

        assign sof = s_axis_tvalid[ch] & s_axis_tready[ch] & s_axis_tuser[ch];

        // The releasing beat must itself be out of reset, hence combinational.
        assign release_sof = (state == ST_ARMED) & sof & (frm_cnt == FRM_LAST) & ~rst_req[ch];

        always_comb begin
            state_nxt    = state;
            hold_cnt_nxt = hold_cnt;
            frm_cnt_nxt  = frm_cnt;
            to_cnt_nxt   = to_cnt;
            flag_nxt     = flag;
            case (state)
                ST_HOLD: begin
                    if (rst_req[ch]) begin
                        hold_cnt_nxt = '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_nxt    = ST_ARMED;
                        hold_cnt_nxt = '0;
                        frm_cnt_nxt  = '0;
                        to_cnt_nxt   = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (rst_req[ch]) begin
                        state_nxt    = ST_HOLD;
                        hold_cnt_nxt = '0;
                    end else if (release_sof) begin
                        state_nxt = ST_RUN;
                    end else if (TO_EN && (to_cnt == TO_LAST)) begin
                        state_nxt = ST_RUN;
                        flag_nxt  = 1'b1;
                    end else begin
                        if (sof && (frm_cnt < FRM_LAST)) begin
                            frm_cnt_nxt = frm_cnt + 1'b1;
                        end
                        if (TO_EN) begin
                            to_cnt_nxt = to_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rst_req[ch]) begin
                        state_nxt    = ST_HOLD;
                        hold_cnt_nxt = '0;
                        flag_nxt     = 1'b0;
                    end
                end
                default: begin
                    state_nxt    = ST_HOLD;
                    hold_cnt_nxt = '0;
                end
            endcase
        end

        always_ff @(posedge aclk) begin
            if (!resetn) begin
                state    <= ST_HOLD;
                hold_cnt <= '0;
                frm_cnt  <= '0;
                to_cnt   <= '0;
                flag     <= 1'b0;
            end else begin
                state    <= state_nxt;
                hold_cnt <= hold_cnt_nxt;
                frm_cnt  <= frm_cnt_nxt;
                to_cnt   <= to_cnt_nxt;
                flag     <= flag_nxt;
            end
        end

        assign resetn_internal[ch] = resetn & ((state == ST_RUN) | release_sof);
        assign timeout_flag[ch]    = flag;
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_aligned_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_aligned_rst_ctrl
// Brief    : Directed bench: default, HOLD_FRAMES=2 and TIMEOUT_CYCLES=50 builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_aligned_rst_ctrl;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic       resetn;
    logic [1:0] a_tv, a_tr, a_tu, a_rq, a_out, a_to;
    logic [0:0] b_tv, b_tr, b_tu, b_rq, b_out, b_to;
    logic [1:0] c_tv, c_tr, c_tu, c_rq, c_out, c_to;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    frame_aligned_rst_ctrl dut_a (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tvalid(a_tv), .s_axis_tready(a_tr), .s_axis_tuser(a_tu),
        .rst_req(a_rq), .resetn_internal(a_out), .timeout_flag(a_to)
    );

    frame_aligned_rst_ctrl #(.NUM_CH(1), .HOLD_FRAMES(2)) dut_b (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tvalid(b_tv), .s_axis_tready(b_tr), .s_axis_tuser(b_tu),
        .rst_req(b_rq), .resetn_internal(b_out), .timeout_flag(b_to)
    );

    frame_aligned_rst_ctrl #(.TIMEOUT_CYCLES(50)) dut_c (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tvalid(c_tv), .s_axis_tready(c_tr), .s_axis_tuser(c_tu),
        .rst_req(c_rq), .resetn_internal(c_out), .timeout_flag(c_to)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0;
        a_tv = '1; a_tr = '1; a_tu = '0; a_rq = '0;
        b_tv = '1; b_tr = '1; b_tu = '0; b_rq = '0;
        c_tv = '1; c_tr = '1; c_tu = '0; c_rq = '0;

        for (int n = 0; n < 275; n++) begin
            @(posedge aclk);
            #1;
            cyc    = n;
            resetn = !((n < 5) || (n == 200));
            a_tu = '0; a_rq = '0;
            b_tu = '0; b_tr = '1;
            c_tu = '0; c_rq = '0;
            case (n)
                15:  a_tu = 2'b01;
                20:  b_tu = 1'b1;
                25:  b_tu = 1'b1;
                30:  a_tu = 2'b01;
                40:  a_tu = 2'b10;
                50:  a_rq = 2'b10;
                60:  a_tu = 2'b10;
                65:  begin b_tu = 1'b1; b_tr = 1'b0; end
                67:  begin a_tu = 2'b10; a_rq = 2'b10; end
                70:  c_tu = 2'b10;
                80:  c_rq = 2'b01;
                90:  a_tu = 2'b10;
                105: b_tu = 1'b1;
                185: b_tu = 1'b1;
                220: a_tu = 2'b01;
                225: a_tu = 2'b10;
                230: b_tu = 1'b1;
                240: b_tu = 1'b1;
                250: b_tu = 1'b1;
                default: ;
            endcase
            #2;

            case (n)
                2: begin
                    chk("reset_a_out", a_out, 2'b00);
                    chk("reset_a_flag", a_to, 2'b00);
                    chk("reset_b_out", {1'b0, b_out}, 2'b00);
                    chk("reset_c_out", c_out, 2'b00);
                    chk("reset_c_flag", c_to, 2'b00);
                end
                15:  chk("a_sof_in_hold", a_out, 2'b00);
                20: begin
                    chk("a_last_hold", a_out, 2'b00);
                    chk("b_sof_on_arm_edge", {1'b0, b_out}, 2'b00);
                end
                21:  chk("a_armed_no_sof", a_out, 2'b00);
                25:  chk("b_first_frame", {1'b0, b_out}, 2'b00);
                29:  chk("a_before_sof", a_out, 2'b00);
                30:  chk("a_sof_release", a_out, 2'b01);
                40:  chk("a_ch1_release", a_out, 2'b11);
                50:  chk("a_req_cycle", a_out, 2'b11);
                51:  chk("a_req_drop", a_out, 2'b01);
                65:  chk("b_stalled_sof", {1'b0, b_out}, 2'b00);
                66:  chk("a_min_hold", a_out, 2'b01);
                67:  chk("a_req_beats_sof", a_out, 2'b01);
                70: begin
                    chk("c_sof_at_expiry", c_out, 2'b10);
                    chk("c_flag_pre", c_to, 2'b00);
                end
                71: begin
                    chk("c_timeout_release", c_out, 2'b11);
                    chk("c_timeout_flag", c_to, 2'b01);
                end
                80: begin
                    chk("c_req_cycle_out", c_out, 2'b11);
                    chk("c_req_cycle_flag", c_to, 2'b01);
                end
                81: begin
                    chk("c_req_drop", c_out, 2'b10);
                    chk("c_req_flag_clr", c_to, 2'b00);
                end
                89:  chk("a_ch1_wait", a_out, 2'b01);
                90:  chk("a_ch1_rerelease", a_out, 2'b11);
                100: chk("a_no_flag", a_to, 2'b00);
                105: chk("b_second_frame", {1'b0, b_out}, 2'b00);
                146: chk("c_second_pre", c_out, 2'b10);
                147: begin
                    chk("c_second_timeout", c_out, 2'b11);
                    chk("c_second_flag", c_to, 2'b01);
                end
                184: chk("b_before_release", {1'b0, b_out}, 2'b00);
                185: chk("b_third_sof", {1'b0, b_out}, 2'b01);
                199: chk("a_before_pulse", a_out, 2'b11);
                200: begin
                    chk("pulse_a_drop", a_out, 2'b00);
                    chk("pulse_b_drop", {1'b0, b_out}, 2'b00);
                    chk("pulse_c_drop", c_out, 2'b00);
                end
                201: begin
                    chk("pulse_a_low", a_out, 2'b00);
                    chk("pulse_c_flag_clr", c_to, 2'b00);
                end
                216: chk("pulse_a_hold", a_out, 2'b00);
                220: chk("pulse_a_ch0", a_out, 2'b01);
                225: chk("pulse_a_ch1", a_out, 2'b11);
                240: chk("pulse_b_second", {1'b0, b_out}, 2'b00);
                249: chk("pulse_b_wait", {1'b0, b_out}, 2'b00);
                250: chk("pulse_b_release", {1'b0, b_out}, 2'b01);
                266: chk("pulse_c_pre", c_out, 2'b00);
                267: begin
                    chk("pulse_c_timeout", c_out, 2'b11);
                    chk("pulse_c_flags", c_to, 2'b11);
                end
                default: ;
            endcase

            if (n >= 30 && n < 200) begin
                chk("a_ch0_steady", {1'b0, a_out[0]}, 2'b01);
            end
            if (n >= 51 && n < 90) begin
                chk("a_ch1_low", {1'b0, a_out[1]}, 2'b00);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
